// File: rtl/apb_ucpd_rx_symdec.sv
// ---------------------------------------------------------------------------
// apb_ucpd_rx_symdec
// Receive-side 4b5b symbol decoder for the UCPD PHY. Hunts the BMC-recovered
// bit stream for a K-code ordered set (3-of-4 symbol match), then assembles
// 5b data symbols into bytes until EOP, an invalid symbol or overflow.
//
// Ports
//   ic_clk       block clock, rising edge
//   ic_rst       asynchronous active-high reset
//   rx_en        decoder enable; low forces IDLE
//   abort        synchronous frame abort
//   bit_vld      bit_in valid strobe (at most one per two clocks)
//   bit_in       line bit, symbol LSB first
//   ordset_en    accept mask [0]SOP [1]SOP' [2]SOP'' [3]SOP'_Dbg [4]SOP''_Dbg
//                [5]HRST [6]CRST
//   sop_det      pulse: enabled SOP-family ordered set found
//   ordset_type  index of last detected ordered set (held)
//   hrst_det     pulse: Hard Reset detected
//   crst_det     pulse: Cable Reset detected
//   byte_vld     pulse: byte_out valid
//   byte_out     decoded byte {hi nibble, lo nibble} (held)
//   byte_cnt     bytes decoded in current frame (saturates at MAX_BYTES)
//   eop_det      pulse: EOP received in DATA
//   sym_err      pulse: invalid symbol, odd nibble count at EOP, or overflow
//   busy         high while in DATA
// ---------------------------------------------------------------------------
module apb_ucpd_rx_symdec #(
  parameter int unsigned MAX_BYTES = 264,
  parameter int unsigned BCNT_W    = 10
) (
  input  logic              ic_clk,
  input  logic              ic_rst,
  input  logic              rx_en,
  input  logic              abort,
  input  logic              bit_vld,
  input  logic              bit_in,
  input  logic [6:0]        ordset_en,
  output logic              sop_det,
  output logic [2:0]        ordset_type,
  output logic              hrst_det,
  output logic              crst_det,
  output logic              byte_vld,
  output logic [7:0]        byte_out,
  output logic [BCNT_W-1:0] byte_cnt,
  output logic              eop_det,
  output logic              sym_err,
  output logic              busy
);

  localparam int unsigned WIN_W = 20;
  localparam int unsigned SYM_W = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HUNT = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  // K-codes, bit[0] is the first bit on the line
  localparam logic [4:0] K_S1  = 5'b11000;
  localparam logic [4:0] K_S2  = 5'b10001;
  localparam logic [4:0] K_S3  = 5'b00110;
  localparam logic [4:0] K_R1  = 5'b00111;
  localparam logic [4:0] K_R2  = 5'b11001;
  localparam logic [4:0] K_EOP = 5'b01101;

  // Ordered-set pattern; first symbol in the low 5 bits
  function automatic logic [WIN_W-1:0] set_pat(input logic [2:0] idx);
    logic [WIN_W-1:0] p;
    case (idx)
      3'd0:    p = {K_S2, K_S1, K_S1, K_S1};
      3'd1:    p = {K_S3, K_S3, K_S1, K_S1};
      3'd2:    p = {K_S3, K_S1, K_S3, K_S1};
      3'd3:    p = {K_S3, K_R2, K_R2, K_S1};
      3'd4:    p = {K_S2, K_S3, K_R2, K_S1};
      3'd5:    p = {K_R2, K_R1, K_R1, K_R1};
      3'd6:    p = {K_S3, K_R1, K_S1, K_R1};
      default: p = '0;
    endcase
    return p;
  endfunction

  // At least three of the four symbols must match exactly
  function automatic logic match34(input logic [WIN_W-1:0] w,
                                   input logic [WIN_W-1:0] p);
    logic [2:0] n;
    n = '0;
    for (int k = 0; k < 4; k++) begin
      if (w[k*SYM_W +: SYM_W] == p[k*SYM_W +: SYM_W]) n = n + 3'd1;
    end
    return (n >= 3'd3);
  endfunction

  // 4b5b data decode: {valid, nibble}
  function automatic logic [4:0] dec_data(input logic [4:0] c);
    logic [4:0] r;
    case (c)
      5'b11110: r = {1'b1, 4'h0};
      5'b01001: r = {1'b1, 4'h1};
      5'b10100: r = {1'b1, 4'h2};
      5'b10101: r = {1'b1, 4'h3};
      5'b01010: r = {1'b1, 4'h4};
      5'b01011: r = {1'b1, 4'h5};
      5'b01110: r = {1'b1, 4'h6};
      5'b01111: r = {1'b1, 4'h7};
      5'b10010: r = {1'b1, 4'h8};
      5'b10011: r = {1'b1, 4'h9};
      5'b10110: r = {1'b1, 4'hA};
      5'b10111: r = {1'b1, 4'hB};
      5'b11010: r = {1'b1, 4'hC};
      5'b11011: r = {1'b1, 4'hD};
      5'b11100: r = {1'b1, 4'hE};
      5'b11101: r = {1'b1, 4'hF};
      default:  r = 5'b0_0000;
    endcase
    return r;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [SYM_W-1:0]  sym_q, sym_d;
  logic [2:0]        bitc_q, bitc_d;
  logic              odd_q, odd_d;
  logic [3:0]        lo_q, lo_d;
  logic              sop_det_q, sop_det_d;
  logic [2:0]        ordset_type_q, ordset_type_d;
  logic              hrst_det_q, hrst_det_d;
  logic              crst_det_q, crst_det_d;
  logic              byte_vld_q, byte_vld_d;
  logic [7:0]        byte_out_q, byte_out_d;
  logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic              eop_det_q, eop_det_d;
  logic              sym_err_q, sym_err_d;
  logic              busy_q, busy_d;

  logic [WIN_W-1:0]  win_shift;
  logic [SYM_W-1:0]  sym_shift;
  logic [6:0]        hit;
  logic [2:0]        sop_idx;
  logic [4:0]        dec;

  // New bits enter at the top so the oldest symbol ends in the low bits
  assign win_shift = {bit_in, win_q[WIN_W-1:1]};
  assign sym_shift = {bit_in, sym_q[SYM_W-1:1]};
  assign dec       = dec_data(sym_shift);

  // Enabled ordered sets matching the window after this shift
  always_comb begin
    hit = '0;
    for (int i = 0; i < 7; i++) begin
      hit[i] = ordset_en[i] & match34(win_shift, set_pat(3'(i)));
    end
  end

  // Lowest-index SOP-family match
  always_comb begin
    sop_idx = 3'd0;
    casez (hit[4:0])
      5'b????1: sop_idx = 3'd0;
      5'b???10: sop_idx = 3'd1;
      5'b??100: sop_idx = 3'd2;
      5'b?1000: sop_idx = 3'd3;
      5'b10000: sop_idx = 3'd4;
      default:  sop_idx = 3'd0;
    endcase
  end

  // Next-state and output logic
  always_comb begin
    state_d       = state_q;
    win_d         = win_q;
    sym_d         = sym_q;
    bitc_d        = bitc_q;
    odd_d         = odd_q;
    lo_d          = lo_q;
    sop_det_d     = 1'b0;
    ordset_type_d = ordset_type_q;
    hrst_det_d    = 1'b0;
    crst_det_d    = 1'b0;
    byte_vld_d    = 1'b0;
    byte_out_d    = byte_out_q;
    byte_cnt_d    = byte_cnt_q;
    eop_det_d     = 1'b0;
    sym_err_d     = 1'b0;

    if (!rx_en || abort) begin
      // disable/abort wins over any coincident bit
      state_d = ST_IDLE;
      win_d   = '0;
      sym_d   = '0;
      bitc_d  = '0;
      odd_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_HUNT;
          win_d   = '0;
        end
        ST_HUNT: begin
          if (bit_vld) begin
            win_d = win_shift;
            if (hit[5]) begin
              hrst_det_d    = 1'b1;
              ordset_type_d = 3'd5;
              win_d         = '0;
            end else if (hit[6]) begin
              crst_det_d    = 1'b1;
              ordset_type_d = 3'd6;
              win_d         = '0;
            end else if (|hit[4:0]) begin
              sop_det_d     = 1'b1;
              ordset_type_d = sop_idx;
              byte_cnt_d    = '0;
              state_d       = ST_DATA;
              win_d         = '0;
              sym_d         = '0;
              bitc_d        = '0;
              odd_d         = 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (bit_vld) begin
            sym_d = sym_shift;
            if (bitc_q == 3'd4) begin
              bitc_d = '0;
              if (dec[4]) begin
                if (!odd_q) begin
                  lo_d  = dec[3:0];
                  odd_d = 1'b1;
                end else begin
                  odd_d = 1'b0;
                  if (byte_cnt_q == BCNT_W'(MAX_BYTES)) begin
                    sym_err_d = 1'b1;
                    state_d   = ST_HUNT;
                  end else begin
                    byte_vld_d = 1'b1;
                    byte_out_d = {dec[3:0], lo_q};
                    byte_cnt_d = byte_cnt_q + BCNT_W'(1);
                  end
                end
              end else if (sym_shift == K_EOP) begin
                // an odd nibble count means a dropped half byte
                eop_det_d = 1'b1;
                sym_err_d = odd_q;
                odd_d     = 1'b0;
                state_d   = ST_HUNT;
              end else begin
                sym_err_d = 1'b1;
                odd_d     = 1'b0;
                state_d   = ST_HUNT;
              end
            end else begin
              bitc_d = bitc_q + 3'd1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d == ST_DATA);
  end

  // State and output registers
  always_ff @(posedge ic_clk or posedge ic_rst) begin
    if (ic_rst) begin
      state_q       <= ST_IDLE;
      win_q         <= '0;
      sym_q         <= '0;
      bitc_q        <= '0;
      odd_q         <= 1'b0;
      lo_q          <= '0;
      sop_det_q     <= 1'b0;
      ordset_type_q <= '0;
      hrst_det_q    <= 1'b0;
      crst_det_q    <= 1'b0;
      byte_vld_q    <= 1'b0;
      byte_out_q    <= '0;
      byte_cnt_q    <= '0;
      eop_det_q     <= 1'b0;
      sym_err_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      win_q         <= win_d;
      sym_q         <= sym_d;
      bitc_q        <= bitc_d;
      odd_q         <= odd_d;
      lo_q          <= lo_d;
      sop_det_q     <= sop_det_d;
      ordset_type_q <= ordset_type_d;
      hrst_det_q    <= hrst_det_d;
      crst_det_q    <= crst_det_d;
      byte_vld_q    <= byte_vld_d;
      byte_out_q    <= byte_out_d;
      byte_cnt_q    <= byte_cnt_d;
      eop_det_q     <= eop_det_d;
      sym_err_q     <= sym_err_d;
      busy_q        <= busy_d;
    end
  end

  assign sop_det     = sop_det_q;
  assign ordset_type = ordset_type_q;
  assign hrst_det    = hrst_det_q;
  assign crst_det    = crst_det_q;
  assign byte_vld    = byte_vld_q;
  assign byte_out    = byte_out_q;
  assign byte_cnt    = byte_cnt_q;
  assign eop_det     = eop_det_q;
  assign sym_err     = sym_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_apb_ucpd_rx_symdec.sv
// ---------------------------------------------------------------------------
// tb_apb_ucpd_rx_symdec
// Scoreboard bench: a symbol-level reference model turns every driven bit
// into expected events; a monitor pops and compares whenever the DUT pulses.
// ---------------------------------------------------------------------------
module tb_apb_ucpd_rx_symdec;

  localparam int unsigned MAXB = 264;
  localparam int unsigned BW   = 10;

  logic          ic_clk = 1'b0;
  logic          ic_rst;
  logic          rx_en, abort, bit_vld, bit_in;
  logic [6:0]    ordset_en;
  logic          sop_det, hrst_det, crst_det, byte_vld, eop_det, sym_err, busy;
  logic [2:0]    ordset_type;
  logic [7:0]    byte_out;
  logic [BW-1:0] byte_cnt;

  apb_ucpd_rx_symdec #(.MAX_BYTES(MAXB), .BCNT_W(BW)) dut (
    .ic_clk(ic_clk), .ic_rst(ic_rst), .rx_en(rx_en), .abort(abort),
    .bit_vld(bit_vld), .bit_in(bit_in), .ordset_en(ordset_en),
    .sop_det(sop_det), .ordset_type(ordset_type), .hrst_det(hrst_det),
    .crst_det(crst_det), .byte_vld(byte_vld), .byte_out(byte_out),
    .byte_cnt(byte_cnt), .eop_det(eop_det), .sym_err(sym_err), .busy(busy)
  );

  always #5 ic_clk = ~ic_clk;

  localparam logic [4:0] S1 = 5'b11000, S2 = 5'b10001, S3 = 5'b00110;
  localparam logic [4:0] R1 = 5'b00111, R2 = 5'b11001, EOP = 5'b01101;

  logic [4:0] dtab [16] = '{5'b11110, 5'b01001, 5'b10100, 5'b10101,
                            5'b01010, 5'b01011, 5'b01110, 5'b01111,
                            5'b10010, 5'b10011, 5'b10110, 5'b10111,
                            5'b11010, 5'b11011, 5'b11100, 5'b11101};
  logic [4:0] sets [7][4] = '{'{S1, S1, S1, S2}, '{S1, S1, S3, S3},
                              '{S1, S3, S1, S3}, '{S1, R2, R2, S3},
                              '{S1, R2, S3, S2}, '{R1, R1, R1, R2},
                              '{R1, S1, R1, S3}};

  // kind: 1 SOP, 2 HRST, 3 CRST, 4 BYTE, 5 EOP, 6 ERR
  typedef struct packed {
    logic [2:0]    kind;
    logic [7:0]    data;
    logic [BW-1:0] cnt;
    logic          err;
  } ev_t;

  ev_t expq[$];
  int  n_vec = 0;
  int  n_err = 0;

  // reference model state
  bit         hunting;
  bit         hq[$];
  bit         sq[$];
  bit         half;
  logic [3:0] m_lo;
  int         m_cnt;

  function automatic void push_ev(input int k, input int d, input int c, input bit e);
    ev_t ev;
    ev.kind = 3'(k);
    ev.data = 8'(d);
    ev.cnt  = BW'(c);
    ev.err  = e;
    expq.push_back(ev);
  endfunction

  function automatic void model_reset();
    hunting = 1'b1;
    hq.delete();
    sq.delete();
    half = 1'b0;
  endfunction

  function automatic void model_bit(input bit b);
    logic [4:0] sy [4];
    bit         hit [7];
    int         code, found, idx;
    if (hunting) begin
      hq.push_back(b);
      if (hq.size() > 20) void'(hq.pop_front());
      // last 20 bits, oldest first; positions never filled read as 0
      for (int k = 0; k < 4; k++)
        for (int j = 0; j < 5; j++) begin
          idx = hq.size() - 20 + 5 * k + j;
          sy[k][j] = (idx >= 0) ? hq[idx] : 1'b0;
        end
      for (int s = 0; s < 7; s++) begin
        int n = 0;
        for (int k = 0; k < 4; k++) if (sy[k] == sets[s][k]) n++;
        hit[s] = ordset_en[s] && (n >= 3);
      end
      if (hit[5]) begin
        push_ev(2, 5, 0, 0);
        hq.delete();
      end else if (hit[6]) begin
        push_ev(3, 6, 0, 0);
        hq.delete();
      end else begin
        for (int s = 0; s < 5; s++) begin
          if (hit[s] && hunting) begin
            push_ev(1, s, 0, 0);
            hunting = 1'b0;
            m_cnt = 0;
            half = 1'b0;
            sq.delete();
            hq.delete();
          end
        end
      end
    end else begin
      sq.push_back(b);
      if (sq.size() == 5) begin
        code = 0;
        for (int j = 0; j < 5; j++) code += int'(sq[j]) << j;
        sq.delete();
        found = -1;
        for (int d = 0; d < 16; d++) if (int'(dtab[d]) == code) found = d;
        if (found >= 0) begin
          if (!half) begin
            m_lo = 4'(found);
            half = 1'b1;
          end else begin
            half = 1'b0;
            if (m_cnt == int'(MAXB)) begin
              push_ev(6, 0, 0, 0);
              hunting = 1'b1;
            end else begin
              m_cnt++;
              push_ev(4, (found << 4) | int'(m_lo), m_cnt, 0);
            end
          end
        end else if (code == int'(EOP)) begin
          push_ev(5, 0, m_cnt, half);
          half = 1'b0;
          hunting = 1'b1;
        end else begin
          push_ev(6, 0, 0, 0);
          half = 1'b0;
          hunting = 1'b1;
        end
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // monitor: every pulse cycle is one observed event
  ev_t obs, ex;
  always @(negedge ic_clk) begin
    if (!ic_rst && (sop_det || hrst_det || crst_det || byte_vld || eop_det || sym_err)) begin
      obs = '0;
      if (sop_det) begin
        obs.kind = 3'd1; obs.data = 8'(ordset_type); obs.cnt = byte_cnt;
      end else if (hrst_det) begin
        obs.kind = 3'd2; obs.data = 8'(ordset_type);
      end else if (crst_det) begin
        obs.kind = 3'd3; obs.data = 8'(ordset_type);
      end else if (byte_vld) begin
        obs.kind = 3'd4; obs.data = byte_out; obs.cnt = byte_cnt; obs.err = sym_err;
      end else if (eop_det) begin
        obs.kind = 3'd5; obs.cnt = byte_cnt; obs.err = sym_err;
      end else begin
        obs.kind = 3'd6;
      end
      n_vec++;
      if (expq.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event: got kind=%0d data=0x%0h cnt=%0d err=%0d, expected none",
                 obs.kind, obs.data, obs.cnt, obs.err);
      end else begin
        ex = expq.pop_front();
        if (obs !== ex) begin
          n_err++;
          $display("FAIL event: got kind=%0d data=0x%0h cnt=%0d err=%0d, expected kind=%0d data=0x%0h cnt=%0d err=%0d",
                   obs.kind, obs.data, obs.cnt, obs.err, ex.kind, ex.data, ex.cnt, ex.err);
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    @(posedge ic_clk); #1;
    bit_vld = 1'b1;
    bit_in  = b;
    model_bit(b);
    @(posedge ic_clk); #1;
    bit_vld = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge ic_clk);
  endtask

  task automatic send_sym(input logic [4:0] c);
    for (int j = 0; j < 5; j++) send_bit(c[j]);
  endtask

  task automatic send_byte(input logic [7:0] v);
    send_sym(dtab[v[3:0]]);
    send_sym(dtab[v[7:4]]);
  endtask

  task automatic preamble(input int n);
    for (int i = 0; i < n; i++) send_bit(1'(i % 2));
  endtask

  task automatic send_set(input int s);
    for (int k = 0; k < 4; k++) send_sym(sets[s][k]);
  endtask

  task automatic settle();
    repeat (3) @(posedge ic_clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({sop_det, ordset_type, hrst_det, crst_det, byte_vld, byte_out,
                byte_cnt, eop_det, sym_err, busy});
  endfunction

  logic [4:0] fq[$];

  initial begin
    ic_rst = 1'b1; rx_en = 1'b0; abort = 1'b0; bit_vld = 1'b0; bit_in = 1'b0;
    ordset_en = 7'h7F;
    model_reset();
    repeat (3) @(posedge ic_clk);
    #1;
    chk("reset_outputs", all_outs(), 32'd0);
    ic_rst = 1'b0;
    rx_en  = 1'b1;
    repeat (2) @(posedge ic_clk);

    // basic frame 0x5A, 0x12
    preamble(64); send_set(0); send_byte(8'h5A); send_byte(8'h12); send_sym(EOP);
    settle();
    chk("frame_byte_cnt", 32'(byte_cnt), 32'd2);
    chk("frame_busy_after_eop", 32'(busy), 32'd0);

    // SOP with corrupted second symbol, accepted and not accepted
    ordset_en = 7'h01;
    preamble(16); send_sym(S1); send_sym(5'b00000); send_sym(S1); send_sym(S2);
    settle();
    chk("corrupt_sop_busy", 32'(busy), 32'd1);
    send_sym(EOP);
    ordset_en = 7'h02;
    preamble(16); send_sym(S1); send_sym(5'b00000); send_sym(S1); send_sym(S2);
    settle();
    chk("corrupt_sop_no_detect_busy", 32'(busy), 32'd0);

    // Hard Reset enabled and disabled
    ordset_en = 7'h7F;
    preamble(16); send_set(5);
    settle();
    chk("hrst_busy", 32'(busy), 32'd0);
    chk("hrst_type", 32'(ordset_type), 32'd5);
    ordset_en = 7'h1F;
    preamble(16); send_set(5);
    settle();

    // odd nibble count at EOP
    ordset_en = 7'h7F;
    preamble(16); send_set(0); send_sym(dtab[7]); send_sym(EOP);
    settle();

    // invalid symbol mid-frame, then a clean frame
    preamble(16); send_set(0); send_sym(dtab[3]); send_sym(5'b00000);
    settle();
    chk("bad_sym_busy", 32'(busy), 32'd0);
    preamble(16); send_set(0); send_byte(8'h33); send_sym(EOP);
    settle();
    chk("recover_byte_cnt", 32'(byte_cnt), 32'd1);

    // randomized frames
    for (int f = 0; f < 30; f++) begin
      ordset_en = 7'($urandom_range(1, 127));
      fq.delete();
      begin
        int s = int'($urandom_range(0, 6));
        for (int k = 0; k < 4; k++) fq.push_back(sets[s][k]);
      end
      for (int b = 0; b < int'($urandom_range(0, 5)); b++) begin
        logic [7:0] r = 8'($urandom);
        fq.push_back(dtab[r[3:0]]);
        fq.push_back(dtab[r[7:4]]);
      end
      if ($urandom_range(0, 9) == 0) fq.push_back(dtab[4'($urandom)]);
      fq.push_back(EOP);
      if ($urandom_range(0, 6) == 0) fq[$urandom_range(0, fq.size() - 1)] = 5'($urandom);
      preamble(8);
      foreach (fq[i]) send_sym(fq[i]);
    end
    settle();

    // overflow: one byte more than MAX_BYTES
    ordset_en = 7'h01;
    model_reset();
    abort = 1'b1; @(posedge ic_clk); #1; abort = 1'b0;
    repeat (2) @(posedge ic_clk);
    preamble(8); send_set(0);
    for (int i = 0; i <= int'(MAXB); i++) send_byte(8'(i));
    send_sym(EOP);
    settle();
    chk("overflow_cnt_sat", 32'(byte_cnt), 32'(MAXB));
    chk("overflow_busy", 32'(busy), 32'd0);

    // abort after three bytes
    preamble(8); send_set(0);
    send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3);
    settle();
    abort = 1'b1; @(posedge ic_clk); #1; abort = 1'b0;
    model_reset();
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge ic_clk);
    send_byte(8'h44); send_byte(8'h55); send_sym(EOP);
    settle();

    // reset in the middle of a byte
    preamble(8); send_set(0); send_byte(8'h9E); send_sym(dtab[2]);
    send_bit(1'b1); send_bit(1'b0);
    settle();
    chk("pre_reset_drained", 32'(expq.size()), 32'd0);
    ic_rst = 1'b1;
    #1;
    chk("midbyte_reset_outputs", all_outs(), 32'd0);
    model_reset();
    repeat (2) @(posedge ic_clk);
    #1;
    chk("reset_hold_outputs", all_outs(), 32'd0);
    ic_rst = 1'b0;
    repeat (2) @(posedge ic_clk);
    ordset_en = 7'h7F;
    preamble(16); send_set(6);
    settle();
    chk("crst_type", 32'(ordset_type), 32'd6);

    settle();
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
